// File: rtl/wbu_cwassemble_pkg.sv
// Shared wbu definitions: codeword prefix constants, the assembler state enum
// and the prefix-to-length decode used by the assembler and decompressor bench.
package wbu_cwassemble_pkg;

    localparam logic [1:0] CW_RDSHORT = 2'b10;
    localparam logic [1:0] CW_RDLONG  = 2'b11;
    localparam logic [2:0] CW_WRCMP   = 3'b010;
    localparam logic [2:0] CW_ADDR    = 3'b001;
    localparam logic [5:0] CW_PASS    = 6'b101110;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    // Pass-through shares the short-read top bits, so it must be tested first.
    function automatic logic [2:0] cw_length(input logic [5:0] p);
        if (p == CW_PASS)
            return 3'd6;
        else if (p[5:4] == CW_RDSHORT)
            return 3'd1;
        else if (p[5:4] == CW_RDLONG)
            return 3'd2;
        else if (p[5:3] == CW_WRCMP)
            return 3'd2;
        else if (p[5:3] == CW_ADDR)
            return 3'd2 + {1'b0, p[2:1]};
        else
            return 3'd6;
    endfunction

endpackage

// File: rtl/wbu_cwassemble_if.sv
// Sextet-in / codeword-out bundle between the sextet decoder, the assembler
// and the codeword decompressor.
interface wbu_cwassemble_if;

    logic        i_stb;
    logic [6:0]  i_bits;
    logic        o_stb;
    logic [35:0] o_word;
    logic        o_busy;
    logic        o_abort;

    modport master (
        output i_stb, i_bits,
        input  o_stb, o_word, o_busy, o_abort
    );

    modport slave (
        input  i_stb, i_bits,
        output o_stb, o_word, o_busy, o_abort
    );

endinterface

// File: rtl/wbu_cwlen.sv
// Combinational decoder from a codeword's first sextet to its total length
// in sextets (1..6).
module wbu_cwlen
    import wbu_cwassemble_pkg::*;
(
    input  logic [5:0] prefix,
    output logic [2:0] len
);

    assign len = cw_length(prefix);

endmodule

// File: rtl/wbu_cwassemble.sv
// Packs 6-bit sextets into left-justified 36-bit codewords whose length is set
// by the first sextet. Define WBU_CWTIMEOUT_EN to discard stalled partial words.
module wbu_cwassemble
    import wbu_cwassemble_pkg::*;
#(
    parameter int TIMEOUT_BITS = 22
) (
    input  logic i_clk,
    input  logic i_reset,
    wbu_cwassemble_if.slave bus
);

    state_t      r_state;
    logic [2:0]  r_need;
    logic [2:0]  r_index;
    logic [35:0] r_word;
    logic        r_stb;
    logic [35:0] r_out_word;
    logic        r_abort;

    logic [5:0]  sextet;
    logic        is_data;
    logic        is_ctrl;
    logic [2:0]  first_len;
    logic [35:0] filled;
    logic        timeout;

    assign sextet  = bus.i_bits[5:0];
    assign is_data = bus.i_stb & ~bus.i_bits[6];
    assign is_ctrl = bus.i_stb &  bus.i_bits[6];

    wbu_cwlen u_cwlen (
        .prefix (sextet),
        .len    (first_len)
    );

`ifdef WBU_CWTIMEOUT_EN
    logic [TIMEOUT_BITS-1:0] r_idle_count;
    logic [TIMEOUT_BITS-1:0] idle_count_next;

    // Counting stops while idle; a sextet in the expiry cycle wins over the timeout.
    assign idle_count_next = r_idle_count + 1'b1;
    assign timeout = (r_state == FILL) && !bus.i_stb && (&idle_count_next);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_idle_count <= '0;
        else if (r_state != FILL || bus.i_stb || timeout)
            r_idle_count <= '0;
        else
            r_idle_count <= idle_count_next;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        filled = r_word;
        case (r_index)
            3'd1:    filled[29:24] = sextet;
            3'd2:    filled[23:18] = sextet;
            3'd3:    filled[17:12] = sextet;
            3'd4:    filled[11:6]  = sextet;
            3'd5:    filled[5:0]   = sextet;
            default: filled[35:30] = sextet;
        endcase
    end

    // Output word is a separate register so it holds steady while the next word builds.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_need     <= 3'd0;
            r_index    <= 3'd0;
            r_word     <= 36'd0;
            r_stb      <= 1'b0;
            r_out_word <= 36'd0;
            r_abort    <= 1'b0;
        end else begin
            r_stb   <= 1'b0;
            r_abort <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (is_data) begin
                        if (first_len == 3'd1) begin
                            r_out_word <= {sextet, 30'd0};
                            r_stb      <= 1'b1;
                        end else begin
                            r_word  <= {sextet, 30'd0};
                            r_need  <= first_len - 3'd1;
                            r_index <= 3'd1;
                            r_state <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (is_data) begin
                        if (r_need == 3'd1) begin
                            r_out_word <= filled;
                            r_stb      <= 1'b1;
                            r_need     <= 3'd0;
                            r_index    <= 3'd0;
                            r_state    <= IDLE;
                        end else begin
                            r_word  <= filled;
                            r_need  <= r_need - 3'd1;
                            r_index <= r_index + 3'd1;
                        end
                    end else if (is_ctrl || timeout) begin
                        r_abort <= 1'b1;
                        r_need  <= 3'd0;
                        r_index <= 3'd0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.o_stb   = r_stb;
    assign bus.o_word  = r_out_word;
    assign bus.o_abort = r_abort;
    assign bus.o_busy  = (r_state == FILL);

endmodule

// File: tb/tb_wbu_cwassemble.sv
// Scoreboard bench for wbu_cwassemble: stimulus queues expected words/aborts
// with their due cycle, a negedge monitor pops and compares them.
module tb_wbu_cwassemble;

    typedef struct {
        logic [35:0] word;
        int          cyc;
    } exp_word_t;

    logic i_clk = 1'b0;
    logic i_reset;
    int   cycle  = 0;
    int   checks = 0;
    int   errors = 0;

    exp_word_t word_q[$];
    int        abort_q[$];

    wbu_cwassemble_if bus_if();

    wbu_cwassemble #(.TIMEOUT_BITS(4)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus_if)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [35:0] actual, input logic [35:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drives one sextet for exactly one clock; returns #1 after the capturing edge.
    task automatic applyStimulus(input logic [6:0] bits);
        bus_if.i_stb  = 1'b1;
        bus_if.i_bits = bits;
        @(posedge i_clk);
        #1;
        bus_if.i_stb  = 1'b0;
        bus_if.i_bits = 7'd0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic expectWord(input logic [35:0] w);
        exp_word_t e;
        e.word = w;
        e.cyc  = cycle;
        word_q.push_back(e);
    endtask

    task automatic expectAbort();
        abort_q.push_back(cycle);
    endtask

    always @(negedge i_clk) begin
        if (!i_reset) begin
            if (bus_if.o_stb) begin
                checks++;
                if (word_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_stb: got word %h at cycle %0d, none expected", bus_if.o_word, cycle);
                end else begin
                    exp_word_t e;
                    e = word_q.pop_front();
                    if (bus_if.o_word !== e.word || cycle != e.cyc) begin
                        errors++;
                        $display("[TB] FAIL word: got %h at cycle %0d, expected %h at cycle %0d",
                                 bus_if.o_word, cycle, e.word, e.cyc);
                    end
                end
            end
            if (bus_if.o_abort) begin
                checks++;
                if (abort_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_abort: got abort at cycle %0d, none expected", cycle);
                end else begin
                    int ec;
                    ec = abort_q.pop_front();
                    if (cycle != ec) begin
                        errors++;
                        $display("[TB] FAIL abort_cycle: got cycle %0d, expected cycle %0d", cycle, ec);
                    end
                end
            end
        end
    end

    initial begin
        i_reset       = 1'b1;
        bus_if.i_stb  = 1'b0;
        bus_if.i_bits = 7'd0;
        repeat (2) @(posedge i_clk);
        #1;
        checkOutput("reset_stb",   {35'd0, bus_if.o_stb},   36'd0);
        checkOutput("reset_word",  bus_if.o_word,           36'd0);
        checkOutput("reset_busy",  {35'd0, bus_if.o_busy},  36'd0);
        checkOutput("reset_abort", {35'd0, bus_if.o_abort}, 36'd0);
        i_reset = 1'b0;
        idleCycles(2);

        $display("[TB] short read");
        applyStimulus(7'h23);
        expectWord(36'h8C0000000);
        checkOutput("short_busy", {35'd0, bus_if.o_busy}, 36'd0);
        idleCycles(2);

        $display("[TB] six-sextet default prefix");
        applyStimulus(7'h00);
        checkOutput("fill_busy", {35'd0, bus_if.o_busy}, 36'd1);
        applyStimulus(7'h01);
        applyStimulus(7'h02);
        applyStimulus(7'h03);
        applyStimulus(7'h04);
        applyStimulus(7'h05);
        expectWord(36'h001083105);
        checkOutput("done_busy", {35'd0, bus_if.o_busy}, 36'd0);
        idleCycles(2);

        $display("[TB] pass-through prefix");
        applyStimulus(7'h2E);
        applyStimulus(7'h3F);
        applyStimulus(7'h00);
        applyStimulus(7'h00);
        applyStimulus(7'h00);
        applyStimulus(7'h01);
        expectWord(36'hBBF000001);
        idleCycles(2);
        checkOutput("word_held", bus_if.o_word, 36'hBBF000001);

        $display("[TB] compressed address lengths");
        applyStimulus(7'h0C);
        applyStimulus(7'h3F);
        applyStimulus(7'h3F);
        applyStimulus(7'h3F);
        expectWord(36'h33FFFF000);
        applyStimulus(7'h08);
        applyStimulus(7'h15);
        expectWord(36'h215000000);
        applyStimulus(7'h0E);
        applyStimulus(7'h01);
        applyStimulus(7'h02);
        applyStimulus(7'h03);
        applyStimulus(7'h04);
        expectWord(36'h381083100);
        idleCycles(2);

        $display("[TB] abort on control character");
        applyStimulus(7'h31);
        applyStimulus(7'h40);
        expectAbort();
        checkOutput("abort_busy", {35'd0, bus_if.o_busy}, 36'd0);
        applyStimulus(7'h21);
        expectWord(36'h840000000);
        idleCycles(2);

        $display("[TB] control in idle is ignored");
        applyStimulus(7'h7F);
        idleCycles(2);

        $display("[TB] back-to-back words");
        applyStimulus(7'h12);
        applyStimulus(7'h2A);
        expectWord(36'h4AA000000);
        applyStimulus(7'h25);
        expectWord(36'h940000000);
        idleCycles(2);

        $display("[TB] stall with stb low");
        applyStimulus(7'h31);
        idleCycles(5);
        checkOutput("stall_busy", {35'd0, bus_if.o_busy}, 36'd1);
        applyStimulus(7'h01);
        expectWord(36'hC41000000);
        idleCycles(2);

        $display("[TB] reset during fill");
        applyStimulus(7'h31);
        i_reset = 1'b1;
        #1;
        checkOutput("midreset_busy",  {35'd0, bus_if.o_busy},  36'd0);
        checkOutput("midreset_abort", {35'd0, bus_if.o_abort}, 36'd0);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        applyStimulus(7'h21);
        expectWord(36'h840000000);
        idleCycles(2);

`ifdef WBU_CWTIMEOUT_EN
        $display("[TB] timeout");
        applyStimulus(7'h31);
        idleCycles(15);
        expectAbort();
        idleCycles(2);
        applyStimulus(7'h31);
        idleCycles(14);
        applyStimulus(7'h02);
        expectWord(36'hC42000000);
        idleCycles(2);
`endif

        idleCycles(4);
        checkOutput("words_pending",  36'(word_q.size()),  36'd0);
        checkOutput("aborts_pending", 36'(abort_q.size()), 36'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
